// File: rtl/register_file_8x32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_file_8x32_pkg
// Purpose  : Shared sizing constants and reset value for the 8x32 register
//            file and its storage sub-module.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package register_file_8x32_pkg;

  localparam int REGFILE_DATA_W   = 32;
  localparam int REGFILE_ADDR_W   = 3;
  localparam int REGFILE_NUM_REGS = 8;

  // Value every register takes on reset.
  localparam logic [REGFILE_DATA_W-1:0] REGFILE_RESET_VAL = '0;

endpackage : register_file_8x32_pkg
`default_nettype wire

// File: rtl/register_file_8x32_register_en.sv
`default_nettype none
// ============================================================================
// Module   : register_en
// Purpose  : DATA_WIDTH-bit storage register with load enable and
//            synchronous active-high reset. Reset wins over en.
// Ports    : clk   - clock, rising edge
//            reset - synchronous active-high reset
//            en    - load enable
//            d     - data in
//            q     - registered data out
// Revision : 1.0 - initial release
// ============================================================================
module register_en
  import register_file_8x32_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= DATA_WIDTH'(REGFILE_RESET_VAL);
    end else if (en) begin
      q <= d;
    end
  end

endmodule : register_en
`default_nettype wire

// File: rtl/register_file_8x32.sv
`default_nettype none
// ============================================================================
// Module   : register_file_8x32
// Purpose  : Eight-entry register file, one synchronous write port and two
//            combinational read ports. Write address decode is internal.
//            Optional macro REGFILE_WRITE_BYPASS_EN forwards wData to a read
//            port in the same cycle when it addresses the register being
//            written (reset low, we high). Without it, reads show stored
//            contents only (old value during the write cycle).
// Ports    : clk            - clock, rising edge
//            reset          - synchronous active-high reset, clears all regs
//            we             - write enable
//            wAddr / wData  - write address / data
//            rAddr0/rAddr1  - read addresses
//            rData0/rData1  - read data
// Revision : 1.0 - initial release
// ============================================================================
module register_file_8x32
  import register_file_8x32_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_W,
  parameter int ADDR_WIDTH = REGFILE_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [ADDR_WIDTH-1:0] rAddr0,
  input  logic [ADDR_WIDTH-1:0] rAddr1,
  output logic [DATA_WIDTH-1:0] rData0,
  output logic [DATA_WIDTH-1:0] rData1
);

  // One-hot (or all-zero) register enables; gating by we keeps X on wAddr
  // from reaching any enable while writes are off.
  logic [REGFILE_NUM_REGS-1:0] to_reg;
  logic [DATA_WIDTH-1:0]       regs [REGFILE_NUM_REGS];

  generate
    for (genvar i = 0; i < REGFILE_NUM_REGS; i++) begin : g_reg
      assign to_reg[i] = we & (wAddr == ADDR_WIDTH'(i));

      register_en #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (to_reg[i]),
        .d     (wData),
        .q     (regs[i])
      );
    end
  endgenerate

  // 8:1 read muxes.
  logic [DATA_WIDTH-1:0] stored0;
  logic [DATA_WIDTH-1:0] stored1;

  assign stored0 = regs[rAddr0];
  assign stored1 = regs[rAddr1];

`ifdef REGFILE_WRITE_BYPASS_EN
  // Write-through forwarding, independent per port.
  logic fwd0;
  logic fwd1;

  assign fwd0   = we & ~reset & (rAddr0 == wAddr);
  assign fwd1   = we & ~reset & (rAddr1 == wAddr);
  assign rData0 = fwd0 ? wData : stored0;
  assign rData1 = fwd1 ? wData : stored1;
`else
  assign rData0 = stored0;
  assign rData1 = stored1;
`endif

endmodule : register_file_8x32
`default_nettype wire

// File: tb/tb_register_file_8x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_8x32
// Purpose  : Self-checking bench for register_file_8x32: array model checked
//            every cycle plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_8x32;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  wAddr;
  logic [31:0] wData;
  logic [2:0]  rAddr0;
  logic [2:0]  rAddr1;
  logic [31:0] rData0;
  logic [31:0] rData1;

  int vectors    = 0;
  int miscompares = 0;

  register_file_8x32 dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wAddr  (wAddr),
    .wData  (wData),
    .rAddr0 (rAddr0),
    .rAddr1 (rAddr1),
    .rData0 (rData0),
    .rData1 (rData1)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- model ----------------
  logic [31:0] model [8];
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) model[k] = 32'h0;
      model_valid = 1'b1;
    end else if (we) begin
      model[wAddr] = wData;
    end
  end

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    if (BYPASS && we && !reset && a == wAddr) return wData;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_rd0", rData0, exp_read(rAddr0));
      check("model_rd1", rData1, exp_read(rAddr1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we = 1'b0; wAddr = 3'd0; wData = 32'h0;
    rAddr0 = 3'd0; rAddr1 = 3'd0;
    cyc();
    reset = 1'b0;
    check("reset_state", rData0, 32'h0);

    // Reset clears all.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wAddr = 3'(i); wData = 32'hFFFF_FFFF;
      cyc();
    end
    we = 1'b0;
    rAddr0 = 3'd7;
    #1 check("ones_written", rData0, 32'hFFFF_FFFF);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rAddr0 = 3'(i); rAddr1 = 3'(7 - i);
      #1;
      check("reset_clr0", rData0, 32'h0);
      check("reset_clr1", rData1, 32'h0);
    end
    cyc();

    // Write/read all addresses.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wAddr = 3'(i); wData = 32'hA5A5_0000 + 32'(i);
      cyc();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rAddr0 = 3'(i); rAddr1 = 3'(i);
      #1;
      check("wr_all_rd0", rData0, 32'hA5A5_0000 + 32'(i));
      check("wr_all_rd1", rData1, 32'hA5A5_0000 + 32'(i));
    end
    rAddr0 = 3'd2; rAddr1 = 3'd7;
    #1;
    check("diff_port0", rData0, 32'hA5A5_0002);
    check("diff_port1", rData1, 32'hA5A5_0007);
    cyc();

    // we=0 blocks writes.
    we = 1'b0; wAddr = 3'd5; wData = 32'hDEAD_BEEF;
    cyc(); cyc(); cyc();
    wAddr = 3'bx; wData = 32'hx;
    cyc();
    wAddr = 3'd0; wData = 32'h0;
    rAddr0 = 3'd5; rAddr1 = 3'd0;
    #1;
    check("we0_hold5", rData0, 32'hA5A5_0005);
    check("we0_hold0", rData1, 32'hA5A5_0000);

    // Reset priority over a simultaneous write.
    cyc();
    reset = 1'b1; we = 1'b1; wAddr = 3'd3; wData = 32'h1234_5678;
    cyc();
    reset = 1'b0; we = 1'b0;
    rAddr0 = 3'd3; rAddr1 = 3'd5;
    #1;
    check("rst_prio3", rData0, 32'h0);
    check("rst_prio5", rData1, 32'h0);

    // First write after reset lands on the next edge.
    we = 1'b1; wAddr = 3'd1; wData = 32'h0000_0055;
    cyc();
    we = 1'b0; rAddr0 = 3'd1;
    #1 check("post_rst_wr", rData0, 32'h0000_0055);

    // Read-during-write.
    we = 1'b1; wAddr = 3'd4; wData = 32'h4444_4444;
    cyc();
    rAddr0 = 3'd4; wData = 32'h0BAD_F00D;
    #1 check("rdw_same_cyc", rData0, BYPASS ? 32'h0BAD_F00D : 32'h4444_4444);
    cyc();
    we = 1'b0;
    #1 check("rdw_next_cyc", rData0, 32'h0BAD_F00D);

    // Back-to-back writes to address 6.
    we = 1'b1; wAddr = 3'd6; wData = 32'h1;
    cyc();
    wData = 32'h2; rAddr0 = 3'd6; rAddr1 = 3'd4;
    #1;
    check("b2b_first", rData0, BYPASS ? 32'h2 : 32'h1);
    check("b2b_other4", rData1, 32'h0BAD_F00D);
    cyc();
    we = 1'b0; rAddr1 = 3'd1;
    #1;
    check("b2b_second", rData0, 32'h2);
    check("b2b_other1", rData1, 32'h0000_0055);
    rAddr1 = 3'd7;
    #1 check("b2b_other7", rData1, 32'h0);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file_8x32
`default_nettype wire
